// File: rtl/ahfp_norm_arb_if.sv
// Bundled operand/result channels for the shared normalisation unit.
// Two requester channels (req0 = adder path, req1 = multiplier path) and one
// tagged result channel. The master side drives operands and accepts results.
interface ahfp_norm_arb_if #(
  parameter int MW = 48,
  parameter int EW = 10
);
  logic          req0_valid;
  logic          req0_ready;
  logic [MW-1:0] req0_mant;
  logic [EW-1:0] req0_exp;
  logic          req1_valid;
  logic          req1_ready;
  logic [MW-1:0] req1_mant;
  logic [EW-1:0] req1_exp;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [MW-1:0] rsp_mant;
  logic [EW-1:0] rsp_exp;
  logic          rsp_zero;

  modport master (
    output req0_valid, req0_mant, req0_exp,
    output req1_valid, req1_mant, req1_exp,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_mant, rsp_exp, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_mant, req0_exp,
    input  req1_valid, req1_mant, req1_exp,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_mant, rsp_exp, rsp_zero
  );
endinterface

// File: rtl/ahfp_norm_arb.sv
// Two-stage normaliser shared by the adder and multiplier mantissa paths.
// Stage 1 captures the round-robin winner; stage 2 performs leading-one
// detection, shifts the leading one to the MSB and adjusts the exponent,
// flushing to zero on a zero mantissa or exponent underflow.
module ahfp_norm_arb #(
  parameter int MW = 48,
  parameter int EW = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  ahfp_norm_arb_if.slave bus
);

  // Shift needed to bring the most significant 1 up to bit MW-1.
  // Scanning upward lets the highest set bit overwrite lower ones.
  function automatic logic [5:0] lzd_shift(input logic [MW-1:0] m);
    logic [5:0] sh;
    sh = 6'd0;
    for (int i = 0; i < MW; i++) begin
      if (m[i]) begin
        sh = 6'(MW - 1 - i);
      end
    end
    return sh;
  endfunction

  logic          last_r;
  logic          s1_valid_r;
  logic [MW-1:0] s1_mant_r;
  logic [EW-1:0] s1_exp_r;
  logic          s1_id_r;
  logic          rsp_valid_r;
  logic          rsp_id_r;
  logic [MW-1:0] rsp_mant_r;
  logic [EW-1:0] rsp_exp_r;
  logic          rsp_zero_r;

  logic          adv1_s;
  logic          adv2_s;
  logic          grant_s;
  logic          accept_s;
  logic [5:0]    sh_s;
  logic [EW-1:0] sh_ext_s;
  logic [MW-1:0] norm_mant_s;
  logic [EW-1:0] norm_exp_s;
  logic          norm_zero_s;

  // Pipeline advance conditions and round-robin grant selection.
  always_comb begin
    adv2_s = !rsp_valid_r || bus.rsp_ready;
    adv1_s = !s1_valid_r || adv2_s;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_r;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    accept_s = adv1_s && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = adv1_s & ~grant_s;
  assign bus.req1_ready = adv1_s &  grant_s;

  // Leading-one normalisation of the stage-1 operand with underflow flush.
  always_comb begin
    sh_s     = lzd_shift(s1_mant_r);
    sh_ext_s = EW'(sh_s);
    if ((s1_mant_r == {MW{1'b0}}) || (sh_ext_s > s1_exp_r)) begin
      norm_mant_s = {MW{1'b0}};
      norm_exp_s  = {EW{1'b0}};
      norm_zero_s = 1'b1;
    end else begin
      norm_mant_s = s1_mant_r << sh_s;
      norm_exp_s  = s1_exp_r - sh_ext_s;
      norm_zero_s = 1'b0;
    end
  end

  // Round-robin pointer: remember the requester of the last accepted operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (accept_s) begin
      last_r <= grant_s;
    end else begin
      last_r <= last_r;
    end
  end

  // Stage 1: capture the granted operand, or drain when it moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_mant_r  <= {MW{1'b0}};
      s1_exp_r   <= {EW{1'b0}};
      s1_id_r    <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_mant_r  <= grant_s ? bus.req1_mant : bus.req0_mant;
      s1_exp_r   <= grant_s ? bus.req1_exp : bus.req0_exp;
      s1_id_r    <= grant_s;
    end else if (adv1_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: register the normalised result; hold it while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_mant_r  <= {MW{1'b0}};
      rsp_exp_r   <= {EW{1'b0}};
      rsp_zero_r  <= 1'b0;
    end else if (adv2_s && s1_valid_r) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= s1_id_r;
      rsp_mant_r  <= norm_mant_s;
      rsp_exp_r   <= norm_exp_s;
      rsp_zero_r  <= norm_zero_s;
    end else if (adv2_s) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_mant  = rsp_mant_r;
  assign bus.rsp_exp   = rsp_exp_r;
  assign bus.rsp_zero  = rsp_zero_r;

endmodule
